// File: rtl/y_mux_pkg.sv
// rtl/y_mux_pkg.sv - shared constants and channel-index helpers for y_rr_mux
package y_mux_pkg;

  localparam int SIZE_DEFAULT = 32;
  localparam int CH_DEFAULT   = 4;

  // Explicit wrap so CH need not be a power of two.
  function automatic int next_ch(input int g, input int ch);
    return (g == ch - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/y_rr_pick.sv
// rtl/y_rr_pick.sv - combinational rotating-priority picker
// Scans ptr, ptr+1, ..., CH-1, 0, ..., ptr-1 and grants the first requester.
module y_rr_pick #(
  parameter int CH   = 4,
  parameter int SELW = $clog2(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [CH-1:0]   gnt,
  output logic [SELW-1:0] g,
  output logic            any
);

  logic [SELW:0]   sum;
  logic [SELW-1:0] idx;

  always_comb begin
    gnt = '0;
    g   = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < CH; k++) begin
      // ptr < CH and k < CH, so a single subtraction wraps the sum.
      sum = {1'b0, ptr} + (SELW+1)'(k);
      if (sum >= (SELW+1)'(CH)) sum = sum - (SELW+1)'(CH);
      idx = sum[SELW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        g        = idx;
      end
    end
  end

endmodule

// File: rtl/y_rr_mux.sv
// rtl/y_rr_mux.sv - CH-way round-robin mux with registered valid/ready output
// Define Y_RR_MUX_FIXPRI_EN for fixed priority (lowest requesting index wins).
module y_rr_mux
  import y_mux_pkg::*;
#(
  parameter  int SIZE = SIZE_DEFAULT,
  parameter  int CH   = CH_DEFAULT,
  localparam int SELW = $clog2(CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH-1:0]      in_valid,
  output logic [CH-1:0]      in_ready,
  input  logic [CH*SIZE-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIZE-1:0]    out_data,
  output logic [SELW-1:0]    out_ch
);

  logic            load;
  logic            xfer;
  logic [CH-1:0]   gnt;
  logic [SELW-1:0] g;
  logic            any;
  logic [SELW-1:0] pick_ptr;

  logic            valid_q, valid_d;
  logic [SIZE-1:0] data_q, data_d;
  logic [SELW-1:0] ch_q, ch_d;

  assign load = !valid_q || out_ready;
  assign xfer = any && load && !rst;

  y_rr_pick #(.CH(CH), .SELW(SELW)) u_pick (
    .req (in_valid),
    .ptr (pick_ptr),
    .gnt (gnt),
    .g   (g),
    .any (any)
  );

  assign in_ready = xfer ? gnt : '0;

`ifdef Y_RR_MUX_FIXPRI_EN
  assign pick_ptr = '0;
`else
  logic [SELW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = SELW'(next_ch(int'(g), CH));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign pick_ptr = ptr_q;
`endif

  // Drain and reload on the same edge keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = in_data[int'(g)*SIZE +: SIZE];
      ch_d    = g;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_y_rr_mux.sv
// tb/tb_y_rr_mux.sv - self-checking bench for y_rr_mux (CH=4 and CH=3 instances)
module tb_y_rr_mux;

  localparam int SZ  = 32;
  localparam int CHA = 4;
  localparam int CHB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [CHA-1:0]    a_valid, a_ready;
  logic [CHA*SZ-1:0] a_data;
  logic              a_ovalid, a_oready;
  logic [SZ-1:0]     a_odata;
  logic [1:0]        a_och;

  logic [CHB-1:0]    b_valid, b_ready;
  logic [CHB*SZ-1:0] b_data;
  logic              b_ovalid, b_oready;
  logic [SZ-1:0]     b_odata;
  logic [1:0]        b_och;

  y_rr_mux #(.SIZE(SZ), .CH(CHA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata), .out_ch(a_och)
  );

  y_rr_mux #(.SIZE(SZ), .CH(CHB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata), .out_ch(b_och)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the CH=4 instance, written from the arbitration rules.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_ch    = 0;
  int          m_ptr   = 0;
  int          last_g  = -1;

  function automatic int pick(input logic [15:0] req, input int ptr, input int ch);
    int start;
`ifdef Y_RR_MUX_FIXPRI_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < ch; k++) begin
      int i;
      i = (start + k) % ch;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic step_a(input string tag);
    int g;
    logic [3:0] exp_rdy;
    logic ld;
    @(negedge clk);
    ld = !m_valid || a_oready;
    g = pick(16'(a_valid), m_ptr, CHA);
    exp_rdy = '0;
    if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, ".in_ready"}, 64'(a_ready), 64'(exp_rdy));
    @(posedge clk);
    last_g = -1;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    end else if (exp_rdy != 0) begin
      m_valid = 1'b1;
      m_data  = a_data[g*SZ +: SZ];
      m_ch    = g;
      m_ptr   = (g + 1) % CHA;
      last_g  = g;
    end else if (m_valid && a_oready) begin
      m_valid = 1'b0;
    end
    #1;
    chk({tag, ".out_valid"}, 64'(a_ovalid), 64'(m_valid));
    chk({tag, ".out_data"},  64'(a_odata),  64'(m_data));
    chk({tag, ".out_ch"},    64'(a_och),    64'(m_ch));
  endtask

  logic [31:0] wa, wb, wc, wd;
  int exp_ch;

  initial begin
    rst = 1'b1;
    a_valid = '0; a_data = '0; a_oready = 1'b0;
    b_valid = '0; b_data = '0; b_oready = 1'b0;
    step_a("reset0");
    step_a("reset1");
    chk("reset.out_valid", 64'(a_ovalid), 64'd0);
    chk("reset.out_ch", 64'(a_och), 64'd0);
    rst = 1'b0;

    // All four requesting, consumer always ready.
    wa = 32'hAAAA_0000; wb = 32'hBBBB_1111; wc = 32'hCCCC_2222; wd = 32'hDDDD_3333;
    a_data = {wd, wc, wb, wa};
    a_valid = 4'b1111;
    a_oready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step_a("all4");
`ifdef Y_RR_MUX_FIXPRI_EN
      exp_ch = 0;
`else
      exp_ch = k % CHA;
`endif
      chk("all4.seq_ch", 64'(a_och), 64'(exp_ch));
      chk("all4.seq_data", 64'(a_odata), 64'(a_data[exp_ch*SZ +: SZ]));
      chk("all4.onehot", 64'($countones(a_ready) <= 1), 64'd1);
    end

    // Stall three cycles, then release: drain and reload on the same edge.
    a_oready = 1'b0;
    for (int k = 0; k < 3; k++) step_a("stall");
    a_oready = 1'b1;
    step_a("release");
    chk("release.valid_held", 64'(a_ovalid), 64'd1);

    a_valid = 4'b0000;
    step_a("drain");

    // Single requester on channel 2.
    a_data[2*SZ +: SZ] = 32'hDEADBEEF;
    a_valid = 4'b0100;
    step_a("ch2");
    chk("ch2.out_ch", 64'(a_och), 64'd2);
    chk("ch2.out_data", 64'(a_odata), 64'hDEADBEEF);
    a_valid = 4'b1010;
    step_a("ch13a");
`ifdef Y_RR_MUX_FIXPRI_EN
    chk("ch13a.first", 64'(a_och), 64'd1);
`else
    chk("ch13a.first", 64'(a_och), 64'd3);
`endif
    if (last_g >= 0) a_valid[last_g] = 1'b0;
    step_a("ch13b");
`ifdef Y_RR_MUX_FIXPRI_EN
    chk("ch13b.second", 64'(a_och), 64'd3);
`else
    chk("ch13b.second", 64'(a_och), 64'd1);
`endif
    a_valid = '0;
    step_a("idle");

    // Reset while holding a word with requests pending.
    a_valid = 4'b1111;
    a_oready = 1'b0;
    step_a("prerst");
    step_a("prerst_hold");
    rst = 1'b1;
    step_a("midrst");
    chk("midrst.out_valid", 64'(a_ovalid), 64'd0);
    chk("midrst.out_ch", 64'(a_och), 64'd0);
    rst = 1'b0;
    a_oready = 1'b1;
    step_a("postrst");
    chk("postrst.first_grant", 64'(a_och), 64'd0);

    // Randomized traffic; producers hold valid/data until granted.
    a_valid = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < CHA; i++) begin
        if (!a_valid[i] && $urandom_range(0, 2) != 0) begin
          a_valid[i] = 1'b1;
          a_data[i*SZ +: SZ] = $urandom;
        end
      end
      a_oready = ($urandom_range(0, 3) != 0);
      step_a("rand");
      if (last_g >= 0) a_valid[last_g] = 1'b0;
    end
    a_valid = '0;

    // CH=3 instance: all requesting, pointer wraps at 2 -> 0.
    b_data = {32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A};
    b_valid = 3'b111;
    b_oready = 1'b1;
    for (int k = 0; k < 7; k++) begin
`ifdef Y_RR_MUX_FIXPRI_EN
      exp_ch = 0;
`else
      exp_ch = k % CHB;
`endif
      @(negedge clk);
      chk("ch3.in_ready", 64'(b_ready), 64'(1 << exp_ch));
      @(posedge clk);
      #1;
      chk("ch3.out_valid", 64'(b_ovalid), 64'd1);
      chk("ch3.out_ch", 64'(b_och), 64'(exp_ch));
      chk("ch3.out_data", 64'(b_odata), 64'(b_data[exp_ch*SZ +: SZ]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/y_rr_mux.md
# y_rr_mux

Parametrised successor to the 4-to-1 datapath mux: a CH-way, SIZE-bit multiplexer whose select is generated internally by a round-robin arbiter, not driven externally. Each input channel has a valid/ready handshake. The winning word is captured in a one-entry output register with its own valid/ready handshake. It sits between several producers (fetch, load/store, debug ports) and a single shared consumer bus.

## Interface
- SIZE, 32, data width per channel (≥1)
- CH, 4, channel count (2..16; need not be a power of two)
- SELW, $clog2(CH), derived localparam: width of channel index
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  CH  bit i: channel i presents a word
- in_ready  out  CH  bit i: channel i's word is taken this cycle
- in_data  in  CH*SIZE  channel i occupies bits [i*SIZE +: SIZE]
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer takes the output word this cycle
- out_data  out  SIZE  registered winning word
- out_ch  out  SELW  index of the channel out_data came from

## Operation
- load = !out_valid | out_ready. The output register can accept a word this cycle.
- ptr (SELW bits) is the highest-priority channel for the next grant.
- Grant g is the first i with in_valid[i] set, scanning ptr, ptr+1, …, CH-1, 0, …, ptr-1.
- in_ready[g] = load & in_valid[g]. All other in_ready bits are 0. At most one in_ready bit is high in any cycle.
- in_ready depends combinationally on in_valid and out_ready. A producer must not make in_valid depend on in_ready.
- Transfer on channel g (in_valid[g] & in_ready[g]) has these effects at the next edge:
  - out_data ← in_data[g]
  - out_ch ← g
  - out_valid ← 1
  - ptr ← g+1, wrapping to 0 when g = CH-1
- Drain (out_valid & out_ready) with no new transfer: out_valid ← 0. out_data and out_ch hold their values.
- Drain and transfer in the same cycle: the register reloads and out_valid stays 1.
- No requests: ptr holds its value and no in_ready bit is asserted.
- Once a channel has asserted in_valid, it holds in_valid and in_data stable until its in_ready is seen.
- The output side obeys the same rule: out_valid and out_data stay stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0. All in_ready bits are 0 during the reset cycle.
- Latency is 1 cycle from the input transfer edge to out_valid/out_data.
- Throughput is one word per cycle while out_ready is held at 1.
- Starvation bound: with all CH channels requesting continuously, each channel is granted exactly once in every CH consecutive transfers.
- Reset mid-operation: any held output word is discarded (out_valid=0 at the next edge) and the pointer returns to 0.
- CH not a power of two: ptr never takes values ≥ CH. Wrap is explicit, not a modulo-2^SELW roll-over.

## Configuration
- Y_RR_MUX_FIXPRI_EN undefined (default): round-robin as described above.
- Y_RR_MUX_FIXPRI_EN defined: fixed priority, with the lowest requesting index winning.
  - ptr logic is compiled out; the scan always starts at 0.
  - All handshake, latency and reset rules are unchanged.
  - The starvation bound does not apply.

## Structure
- Package y_mux_pkg holds:
  - default SIZE and CH constants
  - a wrap-increment function next_ch(g, CH)
- Sub-module y_rr_pick: a purely combinational rotating-priority picker.
  - Inputs: req[CH], ptr.
  - Outputs: one-hot gnt[CH], index g, any.
- The top level contains the load logic, the output register and ptr.

## Test plan
- Reset, then CH=4, SIZE=32; drive in_valid=4'b1111, in_data = {D,C,B,A}, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data A,B,C,D,A; exactly one in_ready bit high each cycle.
- out_ready=0 with out_valid=1 for 3 cycles → in_ready=0, out_data/out_ch stable. Release out_ready → drain and reload on the same edge, out_valid stays 1.
- Only channel 2 requests, value 32'hDEADBEEF → out_ch=2 one cycle later. Then channels 1 and 3 request → channel 3 is granted first (ptr=3), then channel 1.
- CH=3 with all requesting → out_ch 0,1,2,0; ptr never reaches 3.
- Assert rst while out_valid=1 and requests are pending → out_valid=0, out_ch=0, in_ready=0 next cycle; the first grant after reset goes to channel 0.
- With Y_RR_MUX_FIXPRI_EN defined and all requesting → out_ch stays 0 every cycle.
